pipe_ctrl_unit: RTL and testbench
=================================

Name: pipe_ctrl_unit

Overview:
- Pipelined successor to the single-cycle control decoder for the 5-stage MIPS core.
- Decodes the ID-stage instruction into a control bundle and carries it through ID/EX, EX/MEM and MEM/WB control registers.
- Adds load-use and RAW hazard stalling, operand-forwarding selects, and branch/jump flush control.
- Sits between the IF/ID register and the datapath muxes. The datapath keeps its own data pipeline registers.

Parameters:
- ALU_OP_W, 3, width of the ALU_op field.
- REG_W, 5, register address width.
- FWD_EN, 1. 1 = forwarding enabled, stall only on load-use. 0 = no forwarding, stall on any in-flight RAW.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active-low.
- instr_i  in  32  ID-stage instruction from IF/ID.
- flush_i  in  1  branch taken, resolved in MEM stage.
- jump_o  out  1  combinational; ID instruction is j/jal/jr and is not stalled.
- stall_o  out  1  combinational; hold PC and IF/ID.
- flush_ifid_o  out  1  combinational; equals jump_o | flush_i.
- illegal_o  out  1  combinational; unknown opcode in ID.
- ex_alu_op_o  out  ALU_OP_W  registered EX control.
- ex_alusrc_o  out  1  registered EX control.
- ex_regdst_o  out  1  registered EX control.
- ex_fwd_a_o  out  2  registered forward select, operand A: 00 regfile, 01 EX/MEM, 10 MEM/WB.
- ex_fwd_b_o  out  2  registered forward select, operand B; same encoding.
- mem_branch_o  out  1  registered MEM control.
- mem_br_type_o  out  2  00 beq, 01 bne, 10 bge, 11 bgt.
- mem_read_o  out  1  registered MEM control.
- mem_write_o  out  1  registered MEM control.
- wb_regwrite_o  out  1  registered WB control.
- wb_memtoreg_o  out  1  registered WB control.
- wb_jal_o  out  1  registered WB control.
- wb_dest_o  out  REG_W  registered WB destination register.

Behaviour:
- Reset (rst_i low, asynchronous): every registered output and all internal stage registers (dest, regwrite, memread per stage) clear to 0. Combinational outputs follow from the zeroed state.
- Decode, opcode -> ALU_op, ALUSrc, RegWrite, MemRead, MemWrite, MemToReg, Branch, Jump:
  - 000000 R: ALU_op 100, RegDst 1, RegWrite 1. For jr (funct 001000): RegWrite 0, Jump 1.
  - 001000 addi: ALU_op 000, ALUSrc 1, RegWrite 1.
  - 001010 slti: ALU_op 010, ALUSrc 1, RegWrite 1.
  - 000100 beq: ALU_op 001, Branch 1, br_type 00.
  - 000101 bne: ALU_op 101, Branch 1, br_type 01.
  - 000001 bge: ALU_op 110, Branch 1, br_type 10.
  - 000111 bgt: ALU_op 110, Branch 1, br_type 11.
  - 100011 lw: ALU_op 000, ALUSrc 1, MemRead 1, MemToReg 1, RegWrite 1.
  - 101011 sw: ALU_op 000, ALUSrc 1, MemWrite 1.
  - 000010 j: Jump 1.
  - 000011 jal: Jump 1, RegWrite 1, Jal 1, dest 31.
  - Any other opcode: all controls 0, illegal_o 1.
- Destination register: rd for R-type; rt for addi/slti/lw; 31 for jal; 0 otherwise. A destination of 0 never causes a hazard or a forward.
- Source use:
  - rs is used by R, addi, slti, branches, lw, sw.
  - rt is used by R (except jr), branches, sw.
- Hazard, FWD_EN=1: stall_o = 1 when the ID/EX instruction has MemRead=1 and its dest equals a used rs or rt in ID.
- Hazard, FWD_EN=0: stall_o = 1 when a used rs or rt equals the dest of a RegWrite instruction in ID/EX or EX/MEM. The regfile is write-before-read, so MEM/WB does not cause a stall.
- Forwarding (FWD_EN=1), computed in ID and registered with the bundle:
  - Select 01 if the source matches the dest in ID/EX with RegWrite and no MemRead.
  - Otherwise select 10 if it matches EX/MEM with RegWrite.
  - The nearer stage wins.
  - With FWD_EN=0, both selects are always 00.
- Pipeline advance each clock:
  - ID/EX <= decoded bundle, or a bubble (all 0) if stall_o or flush_i.
  - EX/MEM <= ID/EX, or a bubble if flush_i.
  - MEM/WB <= EX/MEM, always.
- Priority: flush_i > stall. When flush_i=1, stall_o=0.
- jump_o = Jump & ~stall_o, so a stalled jr waits for its operand.
- Latency: ID decode appears on ex_* 1 cycle later, mem_* 2 cycles later, wb_* 3 cycles later.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - opcode and funct constants.
  - ALU_op codes.
  - br_type codes.
  - fwd_sel codes.
  - a packed control-bundle struct typedef.
- Sub-module hazard_fwd_unit: combinational stall and forward-select logic, parameterised by FWD_EN.

Test Plan:
- Reset low mid-stream with lw in ID/EX -> all ex_/mem_/wb_ outputs 0 immediately; stall_o 0.
- Back-to-back "lw $8,0($0)" then "add $9,$8,$8" -> stall_o 1 for 1 cycle. ex_* bubble 0. Add then issues with ex_fwd_a_o = ex_fwd_b_o = 10.
- "addi $5,$0,1" then "sub $6,$5,$5" with FWD_EN=1 -> no stall; ex_fwd_a_o = 01 on the sub. With FWD_EN=0 -> stall_o 1 for 2 cycles, then fwd = 00.
- beq in MEM with flush_i=1 while a lw-use stall is pending -> stall_o 0, flush_ifid_o 1. Next ex_* and mem_* are all 0.
- jal in ID -> jump_o 1, flush_ifid_o 1. Three cycles later: wb_regwrite_o 1, wb_jal_o 1, wb_dest_o 31.
- Opcode 111111 -> illegal_o 1, all controls 0 through every stage. Also "add $0,…" followed by a consumer of $0 -> no stall, fwd 00.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings and control-bundle types for the pipelined MIPS control unit.
package pipe_ctrl_pkg;

   localparam int unsigned AluOpW = 3;
   localparam int unsigned RegW   = 5;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_BGE   = 6'b000001;
   localparam logic [5:0] OP_BGT   = 6'b000111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] FUNCT_JR = 6'b001000;

   localparam logic [AluOpW-1:0] ALU_ADD   = 3'b000;
   localparam logic [AluOpW-1:0] ALU_BEQ   = 3'b001;
   localparam logic [AluOpW-1:0] ALU_SLT   = 3'b010;
   localparam logic [AluOpW-1:0] ALU_RTYPE = 3'b100;
   localparam logic [AluOpW-1:0] ALU_BNE   = 3'b101;
   localparam logic [AluOpW-1:0] ALU_CMP   = 3'b110;

   localparam logic [1:0] BR_EQ = 2'b00;
   localparam logic [1:0] BR_NE = 2'b01;
   localparam logic [1:0] BR_GE = 2'b10;
   localparam logic [1:0] BR_GT = 2'b11;

   localparam logic [1:0] FWD_RF    = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b01;
   localparam logic [1:0] FWD_MEMWB = 2'b10;

   localparam logic [RegW-1:0] REG_RA = 5'd31;

   typedef struct packed {
      logic [AluOpW-1:0] alu_op;
      logic              alusrc;
      logic              regdst;
      logic [1:0]        fwd_a;
      logic [1:0]        fwd_b;
   } ex_ctrl_t;

   typedef struct packed {
      logic       branch;
      logic [1:0] br_type;
      logic       memread;
      logic       memwrite;
   } mem_ctrl_t;

   typedef struct packed {
      logic            regwrite;
      logic            memtoreg;
      logic            jal;
      logic [RegW-1:0] dest;
   } wb_ctrl_t;

   typedef struct packed {
      ex_ctrl_t  ex;
      mem_ctrl_t mem;
      wb_ctrl_t  wb;
   } ctrl_t;

   typedef struct packed {
      mem_ctrl_t mem;
      wb_ctrl_t  wb;
   } exmem_ctrl_t;

endpackage

// File: rtl/pipe_ctrl_unit_hazard_fwd_unit.sv
// Combinational load-use / RAW stall detection and operand forward selection.
module hazard_fwd_unit
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned REG_W  = 5,
   parameter int unsigned FWD_EN = 1
) (
   input  logic [REG_W-1:0] rs_i,
   input  logic [REG_W-1:0] rt_i,
   input  logic             use_rs_i,
   input  logic             use_rt_i,
   input  logic [REG_W-1:0] idex_dest_i,
   input  logic             idex_regwrite_i,
   input  logic             idex_memread_i,
   input  logic [REG_W-1:0] exmem_dest_i,
   input  logic             exmem_regwrite_i,
   output logic             hazard_o,
   output logic [1:0]       fwd_a_o,
   output logic [1:0]       fwd_b_o
);

   // Register 0 is hard-wired, so it never creates a dependency.
   function automatic logic src_hit(input logic used, input logic [REG_W-1:0] src,
                                    input logic [REG_W-1:0] dest);
      return used && (src != '0) && (src == dest);
   endfunction

   logic w_a_idex, w_b_idex, w_a_exmem, w_b_exmem;

   always_comb begin
      w_a_idex  = src_hit(use_rs_i, rs_i, idex_dest_i);
      w_b_idex  = src_hit(use_rt_i, rt_i, idex_dest_i);
      w_a_exmem = src_hit(use_rs_i, rs_i, exmem_dest_i);
      w_b_exmem = src_hit(use_rt_i, rt_i, exmem_dest_i);
   end

   if (FWD_EN != 0) begin : g_fwd
      logic w_idex_alu_wr;
      assign w_idex_alu_wr = idex_regwrite_i && !idex_memread_i;
      assign hazard_o = idex_memread_i && (w_a_idex || w_b_idex);

      always_comb begin
         fwd_a_o = FWD_RF;
         fwd_b_o = FWD_RF;
         if (w_a_idex && w_idex_alu_wr)         fwd_a_o = FWD_EXMEM;
         else if (w_a_exmem && exmem_regwrite_i) fwd_a_o = FWD_MEMWB;
         if (w_b_idex && w_idex_alu_wr)         fwd_b_o = FWD_EXMEM;
         else if (w_b_exmem && exmem_regwrite_i) fwd_b_o = FWD_MEMWB;
      end
   end else begin : g_nofwd
      logic w_unused_memread;
      assign w_unused_memread = idex_memread_i;
      // Write-before-read regfile: only ID/EX and EX/MEM producers must be waited out.
      assign hazard_o = ((w_a_idex || w_b_idex) && idex_regwrite_i) ||
                        ((w_a_exmem || w_b_exmem) && exmem_regwrite_i);
      assign fwd_a_o  = FWD_RF;
      assign fwd_b_o  = FWD_RF;
   end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit: ID decode plus ID/EX, EX/MEM, MEM/WB control registers,
// hazard stalling, forward selects and flush handling.
module pipe_ctrl_unit
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned ALU_OP_W = AluOpW,
   parameter int unsigned REG_W    = RegW,
   parameter int unsigned FWD_EN   = 1
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [31:0]         instr_i,
   input  logic                flush_i,
   output logic                jump_o,
   output logic                stall_o,
   output logic                flush_ifid_o,
   output logic                illegal_o,
   output logic [ALU_OP_W-1:0] ex_alu_op_o,
   output logic                ex_alusrc_o,
   output logic                ex_regdst_o,
   output logic [1:0]          ex_fwd_a_o,
   output logic [1:0]          ex_fwd_b_o,
   output logic                mem_branch_o,
   output logic [1:0]          mem_br_type_o,
   output logic                mem_read_o,
   output logic                mem_write_o,
   output logic                wb_regwrite_o,
   output logic                wb_memtoreg_o,
   output logic                wb_jal_o,
   output logic [REG_W-1:0]    wb_dest_o
);

   logic [5:0]       w_opcode, w_funct;
   logic [REG_W-1:0] w_rs, w_rt, w_rd;
   logic             w_unused_shamt;
   ctrl_t            w_dec, w_id_ctrl;
   logic             w_jump, w_illegal, w_use_rs, w_use_rt, w_hazard, w_stall;
   logic [1:0]       w_fwd_a, w_fwd_b;
   ctrl_t            r_idex;
   exmem_ctrl_t      r_exmem;
   wb_ctrl_t         r_memwb;

   assign w_opcode       = instr_i[31:26];
   assign w_rs           = instr_i[25:21];
   assign w_rt           = instr_i[20:16];
   assign w_rd           = instr_i[15:11];
   assign w_funct        = instr_i[5:0];
   assign w_unused_shamt = ^instr_i[10:6];

   always_comb begin
      w_dec     = '0;
      w_jump    = 1'b0;
      w_illegal = 1'b0;
      w_use_rs  = 1'b0;
      w_use_rt  = 1'b0;
      case (w_opcode)
         OP_RTYPE: begin
            w_dec.ex.alu_op = ALU_RTYPE;
            w_dec.ex.regdst = 1'b1;
            w_dec.wb.dest   = w_rd;
            w_use_rs        = 1'b1;
            if (w_funct == FUNCT_JR) begin
               w_jump = 1'b1;
            end else begin
               w_dec.wb.regwrite = 1'b1;
               w_use_rt          = 1'b1;
            end
         end
         OP_ADDI, OP_SLTI: begin
            w_dec.ex.alu_op   = (w_opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
            w_dec.ex.alusrc   = 1'b1;
            w_dec.wb.regwrite = 1'b1;
            w_dec.wb.dest     = w_rt;
            w_use_rs          = 1'b1;
         end
         OP_BEQ, OP_BNE, OP_BGE, OP_BGT: begin
            w_dec.mem.branch = 1'b1;
            w_use_rs         = 1'b1;
            w_use_rt         = 1'b1;
            case (w_opcode)
               OP_BEQ:  begin w_dec.ex.alu_op = ALU_BEQ; w_dec.mem.br_type = BR_EQ; end
               OP_BNE:  begin w_dec.ex.alu_op = ALU_BNE; w_dec.mem.br_type = BR_NE; end
               OP_BGE:  begin w_dec.ex.alu_op = ALU_CMP; w_dec.mem.br_type = BR_GE; end
               default: begin w_dec.ex.alu_op = ALU_CMP; w_dec.mem.br_type = BR_GT; end
            endcase
         end
         OP_LW: begin
            w_dec.ex.alu_op   = ALU_ADD;
            w_dec.ex.alusrc   = 1'b1;
            w_dec.mem.memread = 1'b1;
            w_dec.wb.memtoreg = 1'b1;
            w_dec.wb.regwrite = 1'b1;
            w_dec.wb.dest     = w_rt;
            w_use_rs          = 1'b1;
         end
         OP_SW: begin
            w_dec.ex.alu_op    = ALU_ADD;
            w_dec.ex.alusrc    = 1'b1;
            w_dec.mem.memwrite = 1'b1;
            w_use_rs           = 1'b1;
            w_use_rt           = 1'b1;
         end
         OP_J: w_jump = 1'b1;
         OP_JAL: begin
            w_jump            = 1'b1;
            w_dec.wb.regwrite = 1'b1;
            w_dec.wb.jal      = 1'b1;
            w_dec.wb.dest     = REG_RA;
         end
         default: w_illegal = 1'b1;
      endcase
   end

   hazard_fwd_unit #(
      .REG_W  (REG_W),
      .FWD_EN (FWD_EN)
   ) u_hazard_fwd (
      .rs_i             (w_rs),
      .rt_i             (w_rt),
      .use_rs_i         (w_use_rs),
      .use_rt_i         (w_use_rt),
      .idex_dest_i      (r_idex.wb.dest),
      .idex_regwrite_i  (r_idex.wb.regwrite),
      .idex_memread_i   (r_idex.mem.memread),
      .exmem_dest_i     (r_exmem.wb.dest),
      .exmem_regwrite_i (r_exmem.wb.regwrite),
      .hazard_o         (w_hazard),
      .fwd_a_o          (w_fwd_a),
      .fwd_b_o          (w_fwd_b)
   );

   always_comb begin
      w_id_ctrl          = w_dec;
      w_id_ctrl.ex.fwd_a = w_fwd_a;
      w_id_ctrl.ex.fwd_b = w_fwd_b;
   end

   // A taken branch squashes the stalled instruction anyway, so flush overrides stall.
   assign w_stall      = w_hazard && !flush_i;
   assign stall_o      = w_stall;
   assign jump_o       = w_jump && !w_stall;
   assign flush_ifid_o = jump_o || flush_i;
   assign illegal_o    = w_illegal;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_idex  <= '0;
         r_exmem <= '0;
         r_memwb <= '0;
      end else begin
         r_idex      <= (w_stall || flush_i) ? '0 : w_id_ctrl;
         r_exmem.mem <= flush_i ? '0 : r_idex.mem;
         r_exmem.wb  <= flush_i ? '0 : r_idex.wb;
         r_memwb     <= r_exmem.wb;
      end
   end

   assign ex_alu_op_o   = r_idex.ex.alu_op;
   assign ex_alusrc_o   = r_idex.ex.alusrc;
   assign ex_regdst_o   = r_idex.ex.regdst;
   assign ex_fwd_a_o    = r_idex.ex.fwd_a;
   assign ex_fwd_b_o    = r_idex.ex.fwd_b;
   assign mem_branch_o  = r_exmem.mem.branch;
   assign mem_br_type_o = r_exmem.mem.br_type;
   assign mem_read_o    = r_exmem.mem.memread;
   assign mem_write_o   = r_exmem.mem.memwrite;
   assign wb_regwrite_o = r_memwb.regwrite;
   assign wb_memtoreg_o = r_memwb.memtoreg;
   assign wb_jal_o      = r_memwb.jal;
   assign wb_dest_o     = r_memwb.dest;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench: one forwarding and one non-forwarding instance share stimulus; each is
// checked every cycle against an instruction-level pipeline model.
module tb_pipe_ctrl_unit;

   typedef struct {
      logic [2:0] alu;
      logic       alusrc, regdst, branch;
      logic [1:0] brt;
      logic       mr, mw, rw, m2r, jal, jump, ill;
      logic [4:0] dest;
      logic       use_rs, use_rt;
      logic [4:0] rs, rt;
      logic [1:0] fa, fb;
   } rec_t;

   logic        clk_i   = 1'b0;
   logic        rst_i   = 1'b0;
   logic [31:0] instr_i = 32'd0;
   logic        flush_i = 1'b0;

   logic       jump_s [2], stall_s [2], flush_ifid_s [2], illegal_s [2];
   logic [2:0] alu_s [2];
   logic       alusrc_s [2], regdst_s [2];
   logic [1:0] fwd_a_s [2], fwd_b_s [2];
   logic       branch_s [2];
   logic [1:0] brt_s [2];
   logic       mread_s [2], mwrite_s [2], rw_s [2], m2r_s [2], jal_s [2];
   logic [4:0] dest_s [2];

   int checks = 0;
   int errors = 0;

   rec_t ex_q [2], mem_q [2], wb_q [2];
   rec_t nx_ex [2], nx_mem [2], nx_wb [2];

   always #5 clk_i = ~clk_i;

   // Instance 0 forwards, instance 1 relies purely on stalling.
   for (genvar g = 0; g < 2; g++) begin : g_dut
      pipe_ctrl_unit #(
         .ALU_OP_W (3),
         .REG_W    (5),
         .FWD_EN   (1 - g)
      ) u_dut (
         .clk_i         (clk_i),
         .rst_i         (rst_i),
         .instr_i       (instr_i),
         .flush_i       (flush_i),
         .jump_o        (jump_s[g]),
         .stall_o       (stall_s[g]),
         .flush_ifid_o  (flush_ifid_s[g]),
         .illegal_o     (illegal_s[g]),
         .ex_alu_op_o   (alu_s[g]),
         .ex_alusrc_o   (alusrc_s[g]),
         .ex_regdst_o   (regdst_s[g]),
         .ex_fwd_a_o    (fwd_a_s[g]),
         .ex_fwd_b_o    (fwd_b_s[g]),
         .mem_branch_o  (branch_s[g]),
         .mem_br_type_o (brt_s[g]),
         .mem_read_o    (mread_s[g]),
         .mem_write_o   (mwrite_s[g]),
         .wb_regwrite_o (rw_s[g]),
         .wb_memtoreg_o (m2r_s[g]),
         .wb_jal_o      (jal_s[g]),
         .wb_dest_o     (dest_s[g])
      );
   end

   function automatic rec_t bubble();
      rec_t r;
      r = '{default: '0};
      return r;
   endfunction

   function automatic rec_t decode(input logic [31:0] ins);
      rec_t r;
      logic [5:0] op;
      r    = '{default: '0};
      op   = ins[31:26];
      r.rs = ins[25:21];
      r.rt = ins[20:16];
      case (op)
         6'b000000: begin
            r.alu = 3'b100; r.regdst = 1; r.dest = ins[15:11]; r.use_rs = 1;
            if (ins[5:0] == 6'b001000) r.jump = 1;
            else begin r.rw = 1; r.use_rt = 1; end
         end
         6'b001000: begin r.alu = 3'b000; r.alusrc = 1; r.rw = 1; r.dest = ins[20:16]; r.use_rs = 1; end
         6'b001010: begin r.alu = 3'b010; r.alusrc = 1; r.rw = 1; r.dest = ins[20:16]; r.use_rs = 1; end
         6'b000100: begin r.alu = 3'b001; r.branch = 1; r.brt = 0; r.use_rs = 1; r.use_rt = 1; end
         6'b000101: begin r.alu = 3'b101; r.branch = 1; r.brt = 1; r.use_rs = 1; r.use_rt = 1; end
         6'b000001: begin r.alu = 3'b110; r.branch = 1; r.brt = 2; r.use_rs = 1; r.use_rt = 1; end
         6'b000111: begin r.alu = 3'b110; r.branch = 1; r.brt = 3; r.use_rs = 1; r.use_rt = 1; end
         6'b100011: begin
            r.alu = 3'b000; r.alusrc = 1; r.mr = 1; r.m2r = 1; r.rw = 1;
            r.dest = ins[20:16]; r.use_rs = 1;
         end
         6'b101011: begin r.alu = 3'b000; r.alusrc = 1; r.mw = 1; r.use_rs = 1; r.use_rt = 1; end
         6'b000010: r.jump = 1;
         6'b000011: begin r.jump = 1; r.rw = 1; r.jal = 1; r.dest = 5'd31; end
         default:   r.ill = 1;
      endcase
      return r;
   endfunction

   // Does a used source depend on record p (its load, or any register write)?
   function automatic logic raw(input logic used, input logic [4:0] s, input rec_t p,
                                input logic load_only);
      return used && (s != 0) && (p.dest == s) && (load_only ? p.mr : p.rw);
   endfunction

   function automatic logic [1:0] fwd_sel(input logic used, input logic [4:0] s,
                                          input rec_t ex, input rec_t mem);
      if (!used || s == 0) return 2'b00;
      if (ex.rw && !ex.mr && ex.dest == s) return 2'b01;
      if (mem.rw && mem.dest == s) return 2'b10;
      return 2'b00;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_now();
      for (int k = 0; k < 2; k++) begin
         rec_t d;
         logic haz, stall, jump;
         d = decode(instr_i);
         if (k == 0)
            haz = raw(d.use_rs, d.rs, ex_q[k], 1'b1) || raw(d.use_rt, d.rt, ex_q[k], 1'b1);
         else
            haz = raw(d.use_rs, d.rs, ex_q[k], 1'b0) || raw(d.use_rt, d.rt, ex_q[k], 1'b0) ||
                  raw(d.use_rs, d.rs, mem_q[k], 1'b0) || raw(d.use_rt, d.rt, mem_q[k], 1'b0);
         stall = haz && !flush_i;
         jump  = d.jump && !stall;
         d.fa  = (k == 0) ? fwd_sel(d.use_rs, d.rs, ex_q[k], mem_q[k]) : 2'b00;
         d.fb  = (k == 0) ? fwd_sel(d.use_rt, d.rt, ex_q[k], mem_q[k]) : 2'b00;
         chk($sformatf("comb%0d", k),
             32'({jump_s[k], stall_s[k], flush_ifid_s[k], illegal_s[k]}),
             32'({jump, stall, jump || flush_i, d.ill}));
         chk($sformatf("ex%0d", k),
             32'({alu_s[k], alusrc_s[k], regdst_s[k], fwd_a_s[k], fwd_b_s[k]}),
             32'({ex_q[k].alu, ex_q[k].alusrc, ex_q[k].regdst, ex_q[k].fa, ex_q[k].fb}));
         chk($sformatf("mem%0d", k),
             32'({branch_s[k], brt_s[k], mread_s[k], mwrite_s[k]}),
             32'({mem_q[k].branch, mem_q[k].brt, mem_q[k].mr, mem_q[k].mw}));
         chk($sformatf("wb%0d", k),
             32'({rw_s[k], m2r_s[k], jal_s[k], dest_s[k]}),
             32'({wb_q[k].rw, wb_q[k].m2r, wb_q[k].jal, wb_q[k].dest}));
         nx_wb[k]  = mem_q[k];
         nx_mem[k] = flush_i ? bubble() : ex_q[k];
         nx_ex[k]  = (stall || flush_i) ? bubble() : d;
      end
   endtask

   task automatic commit();
      for (int k = 0; k < 2; k++) begin
         ex_q[k]  = nx_ex[k];
         mem_q[k] = nx_mem[k];
         wb_q[k]  = nx_wb[k];
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         ex_q[k]  = bubble();
         mem_q[k] = bubble();
         wb_q[k]  = bubble();
      end
   endtask

   // Called just after a rising edge: drive, sample mid-cycle, then advance.
   task automatic run_cycle(input logic [31:0] ins, input logic fl);
      instr_i = ins;
      flush_i = fl;
      #4;
      check_now();
      @(posedge clk_i);
      #1;
      commit();
   endtask

   function automatic logic [31:0] r_type(input int rs, input int rt, input int rd,
                                          input logic [5:0] funct);
      return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'd0, funct};
   endfunction

   function automatic logic [31:0] i_type(input logic [5:0] op, input int rs, input int rt,
                                          input int imm);
      return {op, 5'(rs), 5'(rt), 16'(imm)};
   endfunction

   function automatic logic [31:0] rand_instr();
      int rs, rt, rd;
      rs = $urandom_range(0, 3);
      rt = $urandom_range(0, 3);
      rd = $urandom_range(0, 3);
      case ($urandom_range(0, 13))
         0, 1:    return r_type(rs, rt, rd, 6'b100000);
         2:       return r_type(rs, rt, rd, 6'b100010);
         3:       return r_type(rs, 0, 0, 6'b001000);
         4:       return i_type(6'b001000, rs, rt, $urandom_range(0, 255));
         5:       return i_type(6'b001010, rs, rt, 7);
         6:       return i_type(6'b000100, rs, rt, 4);
         7:       return i_type(6'b000101, rs, rt, 4);
         8:       return i_type(6'b000001, rs, rt, 4);
         9:       return i_type(6'b000111, rs, rt, 4);
         10:      return i_type(6'b100011, rs, rt, 0);
         11:      return i_type(6'b101011, rs, rt, 8);
         12:      return {($urandom_range(0, 1) == 0) ? 6'b000010 : 6'b000011, 26'(rd)};
         default: return {($urandom_range(0, 1) == 0) ? 6'b111111 : 6'b010000, 26'd0};
      endcase
   endfunction

   initial begin
      logic [31:0] lw8, add9, addi5, sub6, nop;
      lw8   = i_type(6'b100011, 0, 8, 0);
      add9  = r_type(8, 8, 9, 6'b100000);
      addi5 = i_type(6'b001000, 0, 5, 1);
      sub6  = r_type(5, 5, 6, 6'b100010);
      nop   = 32'd0;

      // Power-on reset
      model_reset();
      #3;
      check_now();
      #1 rst_i = 1'b1;
      @(posedge clk_i);
      #1;
      commit();

      // Load-use: add held in ID until the model says it has issued
      run_cycle(lw8, 1'b0);
      for (int i = 0; i < 3; i++) run_cycle(add9, 1'b0);
      for (int i = 0; i < 3; i++) run_cycle(nop, 1'b0);

      // ALU RAW: forwarded vs stalled
      run_cycle(addi5, 1'b0);
      for (int i = 0; i < 3; i++) run_cycle(sub6, 1'b0);
      for (int i = 0; i < 3; i++) run_cycle(nop, 1'b0);

      // Flush wins over a pending load-use stall
      run_cycle(lw8, 1'b0);
      run_cycle(add9, 1'b1);
      for (int i = 0; i < 3; i++) run_cycle(nop, 1'b0);

      // jal through to write-back
      run_cycle({6'b000011, 26'd100}, 1'b0);
      for (int i = 0; i < 3; i++) run_cycle(nop, 1'b0);

      // Illegal opcode, then $0 producer/consumer
      run_cycle(32'hFC00_0000, 1'b0);
      for (int i = 0; i < 3; i++) run_cycle(nop, 1'b0);
      run_cycle(r_type(1, 2, 0, 6'b100000), 1'b0);
      run_cycle(r_type(0, 0, 3, 6'b100000), 1'b0);
      run_cycle(nop, 1'b0);

      // Asynchronous reset mid-stream with lw in ID/EX
      run_cycle(lw8, 1'b0);
      instr_i = add9;
      flush_i = 1'b0;
      #2 rst_i = 1'b0;
      #1;
      model_reset();
      check_now();
      rst_i = 1'b1;
      @(posedge clk_i);
      #1;
      commit();

      // Randomised traffic
      for (int i = 0; i < 400; i++)
         run_cycle(rand_instr(), ($urandom_range(0, 7) == 0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
